// File: rtl/sin_horner_seq.sv
// sin_horner_seq: sequential odd-polynomial sine approximation in Q2.13.
// One shared signed multiplier is time-multiplexed over a small FSM that
// evaluates sin x = x*(1 + x2*(C3 + x2*(C5 + x2*C7))) one product per cycle.
// Build option: define SIN_HORNER_FOLD_EN to accept angles up to +/-pi and
// fold them into +/-pi/2 in an extra FOLD cycle; otherwise inputs are
// saturated to +/-pi/2 at capture.
module sin_horner_seq #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter logic signed [COEF_W-1:0] C3 = -1365,
  parameter logic signed [COEF_W-1:0] C5 = 68,
  parameter logic signed [COEF_W-1:0] C7 = -2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_sin,
  output logic                     busy
);

  localparam int FRAC = 13;

  localparam logic signed [DATA_W-1:0] ONE_Q   = DATA_W'(8192);
  localparam logic signed [DATA_W-1:0] HALF_PI = DATA_W'(12868);
  localparam logic signed [DATA_W-1:0] PI_Q    = DATA_W'(25736);

`ifdef SIN_HORNER_FOLD_EN
  localparam logic signed [DATA_W-1:0] IN_LIM = PI_Q;
`else
  localparam logic signed [DATA_W-1:0] IN_LIM = HALF_PI;
`endif

  localparam logic signed [DATA_W-1:0] C3_EXT = DATA_W'(C3);
  localparam logic signed [DATA_W-1:0] C5_EXT = DATA_W'(C5);
  localparam logic signed [DATA_W-1:0] C7_EXT = DATA_W'(C7);

`ifdef SIN_HORNER_FOLD_EN
  typedef enum logic [2:0] {
    IDLE, FOLD, SQ, H1, H2, H3, FIN, DONE
  } state_t;
  localparam state_t FIRST = FOLD;
`else
  typedef enum logic [2:0] {
    IDLE, SQ, H1, H2, H3, FIN, DONE
  } state_t;
  localparam state_t FIRST = SQ;
`endif

  state_t state, state_n;

  logic signed [DATA_W-1:0]   x_r;
  logic signed [DATA_W-1:0]   x2_r;
  logic signed [DATA_W-1:0]   t_r;
  logic signed [DATA_W-1:0]   mul_a;
  logic signed [DATA_W-1:0]   mul_b;
  logic signed [DATA_W-1:0]   addend;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   prod_q;
  logic signed [DATA_W-1:0]   acc;

  // Floor shift by FRAC then keep the low DATA_W bits (wraps, no saturation).
  function automatic logic signed [DATA_W-1:0] reduce_q13(
    input logic signed [2*DATA_W-1:0] p
  );
    return p[FRAC +: DATA_W];
  endfunction

  // Clamp a value to the symmetric range [-lim, +lim].
  function automatic logic signed [DATA_W-1:0] sat_sym(
    input logic signed [DATA_W-1:0] v,
    input logic signed [DATA_W-1:0] lim
  );
    if (v > lim)       return lim;
    else if (v < -lim) return -lim;
    else               return v;
  endfunction

  // Reflect an angle in [-pi, pi] into [-pi/2, pi/2] keeping sin unchanged.
  function automatic logic signed [DATA_W-1:0] fold_half_pi(
    input logic signed [DATA_W-1:0] v
  );
    if (v > HALF_PI)       return PI_Q - v;
    else if (v < -HALF_PI) return -PI_Q - v;
    else                   return v;
  endfunction

  assign prod   = mul_a * mul_b;
  assign prod_q = reduce_q13(prod);
  assign acc    = addend + prod_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, handshake outputs and multiplier operand selection.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    mul_a     = x_r;
    mul_b     = x_r;
    addend    = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_n = FIRST;
      end
`ifdef SIN_HORNER_FOLD_EN
      FOLD: state_n = SQ;
`endif
      SQ: begin
        mul_a   = x_r;
        mul_b   = x_r;
        state_n = H1;
      end
      H1: begin
        mul_a   = x2_r;
        mul_b   = C7_EXT;
        addend  = C5_EXT;
        state_n = H2;
      end
      H2: begin
        mul_a   = x2_r;
        mul_b   = t_r;
        addend  = C3_EXT;
        state_n = H3;
      end
      H3: begin
        mul_a   = x2_r;
        mul_b   = t_r;
        addend  = ONE_Q;
        state_n = FIN;
      end
      FIN: begin
        mul_a   = x_r;
        mul_b   = t_r;
        state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Working registers: angle capture/fold, x^2 and the Horner accumulator.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) x_r <= sat_sym(in_x, IN_LIM);
`ifdef SIN_HORNER_FOLD_EN
      FOLD: x_r <= fold_half_pi(x_r);
`endif
      SQ:         x2_r <= prod_q;
      H1, H2, H3: t_r  <= acc;
      default: ;
    endcase
  end

  // Result register: loaded in FIN, held until the next FIN.
  always_ff @(posedge clk) begin
    if (rst)              out_sin <= '0;
    else if (state == FIN) out_sin <= prod_q;
  end

`ifndef SIN_HORNER_FOLD_EN
  // fold_half_pi and PI_Q are only used by the folding build.
  logic unused_fold;
  assign unused_fold = ^{fold_half_pi(x_r), PI_Q};
`endif

endmodule

// File: tb/tb_sin_horner_seq.sv
// Directed self-checking bench for sin_horner_seq with hand-computed vectors.
module tb_sin_horner_seq;

`ifdef SIN_HORNER_FOLD_EN
  localparam int LAT      = 6;
  localparam int Y_17544  = 6893;
  localparam int X2_17544 = 8192;
  localparam int T_17544  = 6893;
`else
  localparam int LAT      = 5;
  localparam int Y_17544  = 8177;
  localparam int X2_17544 = 20213;
  localparam int T_17544  = 5206;
`endif

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_x;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_sin;
  logic               busy;

  int n_cmp;
  int n_bad;

  sin_horner_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sin   (out_sin),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One request; releases the result only if out_ready is already high.
  task automatic do_req(input string tag, input int x, input int exp_x2,
                        input int exp_t, input int exp_y);
    int  cyc;
    bit  seen;
    @(negedge clk);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_x     = 16'(x);
    step();
    in_valid = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (cyc == LAT - 4) check({tag, "_x2"}, int'(dut.x2_r), exp_x2);
      if (cyc == LAT - 1) check({tag, "_t"}, int'(dut.t_r), exp_t);
      step();
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_out_sin"}, int'(out_sin), exp_y);
    if (out_ready) begin
      step();
      check({tag, "_ready_after"}, int'(in_ready), 1);
      check({tag, "_valid_after"}, int'(out_valid), 0);
    end
  endtask

  initial begin
    int vcount;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_sin", int'(out_sin), 0);
    rst = 1'b0;

    do_req("x0",     0,     0,     8192, 0);
    do_req("x8192",  8192,  8192,  6893, 6893);
    do_req("xm8192", -8192, 8192,  6893, -6893);
    do_req("x12868", 12868, 20213, 5206, 8177);
    do_req("x17544", 17544, X2_17544, T_17544, Y_17544);

    // Back-pressure: result must hold while ignored requests arrive.
    out_ready = 1'b0;
    do_req("hold", 8192, 8192, 6893, 6893);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_sin", int'(out_sin), 6893);
      check("hold_in_ready", int'(in_ready), 0);
      in_valid = (i % 2 == 0);
      in_x     = -16'sd5000;
      step();
    end
    in_valid = 1'b0;
    check("hold_valid_end", int'(out_valid), 1);
    check("hold_sin_end", int'(out_sin), 6893);
    out_ready = 1'b1;
    step();
    check("release_in_ready", int'(in_ready), 1);
    check("release_valid", int'(out_valid), 0);
    check("release_sin_kept", int'(out_sin), 6893);

    // Reset in H2 abandons the evaluation.
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 16'sd12868;
    step();
    in_valid = 1'b0;
    repeat (LAT - 3) step();
    check("h2_busy", int'(busy), 1);
    check("h2_state", int'(dut.state == dut.H2), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(out_valid), 0);
    check("abort_sin", int'(out_sin), 0);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) vcount++;
      step();
    end
    check("abort_no_result", vcount, 0);
    do_req("post_rst", 8192, 8192, 6893, 6893);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
